uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter. It is the transmit counterpart of the team's UART receiver, and the frame format matches it: start bit 0, 8 data bits LSB first, optional parity, stop bit(s) 1.
- Bit timing comes from the shared baud-rate generator through the same i_bd tick strobe the receiver uses.
- It sits between the TX-side interface logic (which presents a byte plus a start strobe) and the board's serial TX pin.

Parameters:
- TICKS_PER_BIT, 16, number of i_bd pulses per serial bit period (legal range 1..256).
- PARITY_EN, 0, 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0, with PARITY_EN=1: 0 gives even parity, 1 gives odd parity.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- i_Clock  input  1  system clock; all state changes on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_bd  input  1  baud tick, one i_Clock cycle wide.
- i_Tx_Start  input  1  request to send i_Tx_Byte; sampled every cycle.
- i_Tx_Byte  input  8  byte to transmit; captured only when a start is accepted.
- o_Tx_Serial  output  1  serial line, registered, idle high.
- o_Tx_Busy  output  1  high while a frame is in progress.
- o_Tx_Done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, o_Tx_Serial=1, o_Tx_Busy=0, o_Tx_Done=0, tick counter=0, bit index=0, shift register=0.
- Reset mid-frame aborts the frame immediately. The line returns high without waiting for a clock edge, and no Done pulse is produced.
- States: IDLE, START, DATA, PARITY, STOP.
- Tick counter: increments only on cycles where i_bd=1. A bit period ends on the i_bd cycle where counter == TICKS_PER_BIT-1; on that cycle the counter clears to 0.
- Every bit therefore lasts exactly TICKS_PER_BIT ticks.
- IDLE:
  - o_Tx_Serial=1, o_Tx_Busy=0.
  - If i_Tx_Start=1: latch i_Tx_Byte into the shift register, compute and latch the parity bit, clear the counter, go to START.
  - Next edge: o_Tx_Serial=0 and o_Tx_Busy=1. Latency from start to line going low is one clock.
- START: drive 0. At end of bit period go to DATA with bit index 0.
- DATA:
  - Drive shift register bit[index].
  - At end of each bit period: index increments. After index 7 completes, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: drive the latched parity bit. Even mode is XOR of the 8 data bits; odd mode is its inverse. At end of bit period go to STOP.
- STOP:
  - Drive 1 for STOP_BITS bit periods.
  - At end of the final period: go to IDLE, pulse o_Tx_Done=1 for exactly one cycle, and drop o_Tx_Busy on the same edge.
- i_Tx_Start while busy is ignored. i_Tx_Byte changes while busy have no effect.
- Back-to-back: i_Tx_Start=1 in the same cycle o_Tx_Done=1 (state IDLE) is accepted. The next start bit begins one clock later with no extra idle bit.
- If i_bd stays low, state and line hold indefinitely.
- i_bd=1 on the acceptance cycle does not count toward the start bit.
- Frame length in ticks is TICKS_PER_BIT × (1 + 8 + PARITY_EN + STOP_BITS).
- No combinational path from any input to o_Tx_Serial.

Decomposition:
- Shared package uart_pkg holds:
  - the state encodings, 3-bit: IDLE=000, START=001, DATA=010, PARITY=011, STOP=100. These codes also apply to the receiver.
  - the constants DATA_BITS=8, LINE_IDLE=1'b1, START_LEVEL=1'b0.
- The baud generator stays external, so i_bd is shared with the receiver.
- No sub-module. One FSM plus the tick counter, bit index and shift register fit in about 150 lines.

Test Plan:
- Basic frame (defaults, i_bd every cycle): send 0x55.
  - Line reads 0, 1,0,1,0,1,0,1,0, 1, each level held 16 clocks.
  - Done pulses once, 160 clocks after the line first drops.
  - Busy is high for exactly those 160 clocks.
- Even parity (PARITY_EN=1, PARITY_ODD=0): send 0xA5 -> parity bit 0. Send 0xA4 -> parity bit 1. Frame is 11 bits.
- Odd parity with two stop bits (PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2): send 0x03 -> parity bit 1, followed by 32 ticks high, then Done.
- Start while busy: send 0x0F; pulse start with 0xFF mid-DATA.
  - Only the 0x0F frame appears and only one Done pulse occurs.
  - A start plus 0x81 asserted in the Done cycle produces an immediately following 0x81 frame with no gap.
- Reset mid-frame: assert i_reset during data bit 3 of 0x00.
  - Line goes high before the next clock edge.
  - Busy=0 and no Done pulse.
  - After release, a new 0x3C frame is transmitted correctly.
- Tick gating (TICKS_PER_BIT=4, i_bd every 3rd cycle): send 0xC3.
  - Each bit lasts 12 clocks.
  - Holding i_bd low for 50 cycles mid-bit freezes the line level and bit position.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes and line levels common to the
// transmitter and receiver.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_START  = 3'b001;
  localparam logic [2:0] ST_DATA   = 3'b010;
  localparam logic [2:0] ST_PARITY = 3'b011;
  localparam logic [2:0] ST_STOP   = 3'b100;

  localparam int   DATA_BITS   = 8;
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Even parity is the XOR of the data bits; odd parity inverts it.
  function automatic logic calc_parity(input logic [7:0] i_data, input logic i_odd);
    return (^i_data) ^ i_odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-side handshake between the TX interface logic and the UART transmitter.
interface uart_tx_if;
  logic       i_Tx_Start;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Busy;
  logic       o_Tx_Done;

  modport master (output i_Tx_Start, output i_Tx_Byte, input o_Tx_Busy, input o_Tx_Done);
  modport slave  (input i_Tx_Start, input i_Tx_Byte, output o_Tx_Busy, output o_Tx_Done);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit(s).
// state  | meaning
// IDLE   | line high, waiting for a start request
// START  | driving the start bit
// DATA   | driving data bit r_idx
// PARITY | driving the latched parity bit
// STOP   | driving stop bit(s), Done on the last one
module uart_tx
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = 16,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic      i_Clock,
  input  logic      i_reset,
  input  logic      i_bd,
  uart_tx_if.slave  tx_if,
  output logic      o_Tx_Serial
);

  localparam logic [7:0] C_LAST_TICK = 8'(TICKS_PER_BIT - 1);
  localparam logic [2:0] C_LAST_IDX  = 3'(DATA_BITS - 1);
  localparam logic       C_LAST_STOP = 1'(STOP_BITS - 1);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [2:0] r_idx;
  logic [7:0] r_shift;
  logic       r_parity;
  logic       r_stop;
  logic       r_serial;
  logic       r_busy;
  logic       r_done;
  logic       w_bit_end;

  assign w_bit_end       = i_bd && (r_cnt == C_LAST_TICK);
  assign o_Tx_Serial     = r_serial;
  assign tx_if.o_Tx_Busy = r_busy;
  assign tx_if.o_Tx_Done = r_done;

  always_ff @(posedge i_Clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_idx    <= 3'd0;
      r_shift  <= 8'd0;
      r_parity <= 1'b0;
      r_stop   <= 1'b0;
      r_serial <= LINE_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // The acceptance cycle never counts a tick; counting starts in START.
      if (r_state != ST_IDLE && i_bd) begin
        r_cnt <= w_bit_end ? 8'd0 : r_cnt + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          r_serial <= LINE_IDLE;
          r_busy   <= 1'b0;
          if (tx_if.i_Tx_Start) begin
            r_shift  <= tx_if.i_Tx_Byte;
            r_parity <= calc_parity(tx_if.i_Tx_Byte, PARITY_ODD != 0);
            r_cnt    <= 8'd0;
            r_idx    <= 3'd0;
            r_stop   <= 1'b0;
            r_serial <= START_LEVEL;
            r_busy   <= 1'b1;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_idx    <= 3'd0;
            r_serial <= r_shift[0];
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_idx == C_LAST_IDX) begin
              if (PARITY_EN != 0) begin
                r_serial <= r_parity;
                r_state  <= ST_PARITY;
              end else begin
                r_stop   <= 1'b0;
                r_serial <= LINE_IDLE;
                r_state  <= ST_STOP;
              end
            end else begin
              r_idx    <= r_idx + 3'd1;
              r_serial <= r_shift[r_idx + 3'd1];
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_stop   <= 1'b0;
            r_serial <= LINE_IDLE;
            r_state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (r_stop == C_LAST_STOP) begin
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_serial <= LINE_IDLE;
              r_state  <= ST_IDLE;
            end else begin
              r_stop <= r_stop + 1'b1;
            end
          end
        end
        default: begin
          r_serial <= LINE_IDLE;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations share one clock; a queue of expected
// line levels is filled at each start and drained at mid-bit sample points.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tbyte = 8'h00;
  logic [1:0] sel = 2'd0;
  logic       bd_en = 1'b1;
  int         div = 0;
  logic       bd3;
  logic       ser0, ser1, ser2, ser3;
  logic       line_m, busy_m, done_m;

  int n_chk = 0;
  int n_err = 0;
  bit exp_q[$];
  int cfg_pe = 0;
  int cfg_po = 0;
  int cfg_sb = 1;

  initial forever #5 clk = ~clk;

  // Tick every third cycle for the gated instance; freezing bd_en also freezes
  // the divider so the tick stream is simply delayed.
  assign bd3 = bd_en && (div == 2);
  initial forever begin
    @(negedge clk);
    if (bd_en) div = (div == 2) ? 0 : div + 1;
  end

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();
  uart_tx_if if3 ();

  assign if0.i_Tx_Start = start && (sel == 2'd0);
  assign if1.i_Tx_Start = start && (sel == 2'd1);
  assign if2.i_Tx_Start = start && (sel == 2'd2);
  assign if3.i_Tx_Start = start && (sel == 2'd3);
  assign if0.i_Tx_Byte  = tbyte;
  assign if1.i_Tx_Byte  = tbyte;
  assign if2.i_Tx_Byte  = tbyte;
  assign if3.i_Tx_Byte  = tbyte;

  uart_tx #(.TICKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .i_Clock(clk), .i_reset(rst), .i_bd(1'b1), .tx_if(if0.slave), .o_Tx_Serial(ser0));
  uart_tx #(.TICKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .i_Clock(clk), .i_reset(rst), .i_bd(1'b1), .tx_if(if1.slave), .o_Tx_Serial(ser1));
  uart_tx #(.TICKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
    .i_Clock(clk), .i_reset(rst), .i_bd(1'b1), .tx_if(if2.slave), .o_Tx_Serial(ser2));
  uart_tx #(.TICKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut3 (
    .i_Clock(clk), .i_reset(rst), .i_bd(bd3), .tx_if(if3.slave), .o_Tx_Serial(ser3));

  always_comb begin
    line_m = 1'b1;
    busy_m = 1'b0;
    done_m = 1'b0;
    case (sel)
      2'd0: begin line_m = ser0; busy_m = if0.o_Tx_Busy; done_m = if0.o_Tx_Done; end
      2'd1: begin line_m = ser1; busy_m = if1.o_Tx_Busy; done_m = if1.o_Tx_Done; end
      2'd2: begin line_m = ser2; busy_m = if2.o_Tx_Busy; done_m = if2.o_Tx_Done; end
      default: begin line_m = ser3; busy_m = if3.o_Tx_Busy; done_m = if3.o_Tx_Done; end
    endcase
  end

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    if (cfg_pe != 0) exp_q.push_back((^b) ^ (cfg_po != 0));
    for (int s = 0; s < cfg_sb; s++) exp_q.push_back(1'b1);
  endtask

  // Returns one negedge after the accepting edge (frame position n=1).
  task automatic send(input logic [7:0] b);
    push_frame(b);
    nclk();
    if (sel == 2'd3) begin
      for (int k = 0; k < 6 && !bd3; k++) nclk();
    end
    start = 1'b1;
    tbyte = b;
    nclk();
    start = 1'b0;
  endtask

  task automatic run_frame(input int bclk, input int nbits, input int inj_n,
                           input int frz_n, input bit chain, input logic [7:0] nb);
    int  len;
    int  busy_cnt;
    int  done_cnt;
    int  done_at;
    int  chg;
    bit  lv;
    bit  ev;
    len      = bclk * nbits;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int n = 1; n <= len + 1; n++) begin
      if (n > 1) nclk();
      if (n == frz_n) begin
        lv    = line_m;
        chg   = 0;
        bd_en = 1'b0;
        repeat (50) begin
          nclk();
          if (line_m !== lv || done_m !== 1'b0) chg++;
        end
        bd_en = 1'b1;
        chk_eq("freeze_hold", chg, 0);
      end
      if (busy_m === 1'b1) busy_cnt++;
      if (done_m === 1'b1) begin
        done_cnt++;
        done_at = n;
      end
      if (((n - 1) % bclk) == (bclk / 2) && ((n - 1) / bclk) < nbits) begin
        if (exp_q.size() == 0) begin
          chk_eq("queue_underrun", 0, 1);
        end else begin
          ev = exp_q.pop_front();
          chk_eq("line_bit", int'(line_m), int'(ev));
        end
      end
      if (n == inj_n) begin
        start = 1'b1;
        tbyte = 8'hFF;
      end
      if (n == inj_n + 1) start = 1'b0;
      if (n == len + 1 && chain) begin
        start = 1'b1;
        tbyte = nb;
        push_frame(nb);
      end
    end
    chk_eq("busy_len", busy_cnt, len);
    chk_eq("done_count", done_cnt, 1);
    chk_eq("done_at", done_at, len + 1);
  endtask

  initial begin
    int dcnt;
    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_line", int'(ser0), 1);
    chk_eq("rst_busy", int'(if0.o_Tx_Busy), 0);
    chk_eq("rst_done", int'(if0.o_Tx_Done), 0);
    chk_eq("rst_line3", int'(ser3), 1);
    rst = 1'b0;
    nclk();

    // Default config: basic frame, start-while-busy, back-to-back.
    sel = 2'd0; cfg_pe = 0; cfg_po = 0; cfg_sb = 1;
    send(8'h55);
    chk_eq("first_low", int'(line_m), 0);
    run_frame(16, 10, 0, 0, 1'b0, 8'h00);
    send(8'h0F);
    run_frame(16, 10, 16 * 3 + 4, 0, 1'b1, 8'h81);
    nclk();
    start = 1'b0;
    chk_eq("b2b_no_gap", int'(line_m), 0);
    chk_eq("b2b_busy", int'(busy_m), 1);
    run_frame(16, 10, 0, 0, 1'b0, 8'h00);

    // Reset during data bit 3 of 0x00.
    send(8'h00);
    repeat (71) nclk();
    chk_eq("pre_rst_line", int'(line_m), 0);
    #1;
    rst = 1'b1;
    #1;
    chk_eq("rst_async_line", int'(line_m), 1);
    chk_eq("rst_async_busy", int'(busy_m), 0);
    dcnt = 0;
    repeat (3) begin
      nclk();
      if (done_m === 1'b1) dcnt++;
    end
    rst = 1'b0;
    repeat (2) begin
      nclk();
      if (done_m === 1'b1) dcnt++;
    end
    chk_eq("rst_no_done", dcnt, 0);
    chk_eq("rst_idle_busy", int'(busy_m), 0);
    exp_q.delete();
    send(8'h3C);
    run_frame(16, 10, 0, 0, 1'b0, 8'h00);

    // Even parity.
    sel = 2'd1; cfg_pe = 1; cfg_po = 0; cfg_sb = 1;
    send(8'hA5);
    run_frame(16, 11, 0, 0, 1'b0, 8'h00);
    send(8'hA4);
    run_frame(16, 11, 0, 0, 1'b0, 8'h00);

    // Odd parity, two stop bits.
    sel = 2'd2; cfg_pe = 1; cfg_po = 1; cfg_sb = 2;
    send(8'h03);
    run_frame(16, 12, 0, 0, 1'b0, 8'h00);

    // Tick gating: 4 ticks per bit, tick every third clock, then a freeze.
    sel = 2'd3; cfg_pe = 0; cfg_po = 0; cfg_sb = 1;
    send(8'hC3);
    run_frame(12, 10, 0, 0, 1'b0, 8'h00);
    send(8'hC3);
    run_frame(12, 10, 0, 12 * 3 + 4, 1'b0, 8'h00);

    chk_eq("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
